noc_dest_queue: RTL
===================

NOC_DEST_QUEUE -- requirements
Module: noc_dest_queue

Interface
REQ-001 SHALL have parameter NUM_DEST, default 3: number of destination queues, range 1..2**ADDR_W.
REQ-002 SHALL have parameter DEPTH, default 4: flits per queue, power of two, at least 2.
REQ-003 SHALL have parameters ADDR_W=2, TYPE_W=2 and PAYLOAD_W=8: packet field widths, so PKT_W = ADDR_W+TYPE_W+PAYLOAD_W+1.
REQ-004 SHALL have port clk  in  1: the single clock, rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port packet  in  PKT_W: fields dest=[ADDR_W-1:0], type, payload, and end_of_packet (eop) as the MSB.
REQ-007 SHALL have port src_valid  in  1: source flit valid.
REQ-008 SHALL have port src_ready  out  1: block accepts the flit this cycle.
REQ-009 SHALL have port dst_valid  out  NUM_DEST: head flit valid, one bit per queue.
REQ-010 SHALL have port dst_ready  in  NUM_DEST: per-queue consumer ready.
REQ-011 SHALL have port dst_data  out  NUM_DEST*(PKT_W-ADDR_W): per-queue head {eop,payload,type}, with queue i in slice i.
REQ-012 SHALL have port drop_count  out  8: count of dropped packets.

Function
REQ-013 SHALL transfer a source flit when src_valid and src_ready are both 1 on a clk edge, and a destination flit when dst_valid[i] and dst_ready[i] are both 1.
REQ-014 SHALL implement the routing FSM with states IDLE, IN_PKT and DROP.
REQ-015 SHALL, in IDLE, route to queue dest when dest < NUM_DEST, and otherwise enter DROP.
REQ-016 SHALL, in IDLE, stay in IDLE when an accepted flit has eop=1, and otherwise go to IN_PKT and lock the dest.
REQ-017 SHALL, in IN_PKT, route every flit to the locked queue regardless of its dest field (wormhole), and return to IDLE on an accepted eop.
REQ-018 SHALL, in DROP, hold src_ready=1, discard flits, and return to IDLE on an accepted eop.
REQ-019 SHALL drive src_ready from the target queue's registered not-full flag in IDLE or IN_PKT, so a pop in the same cycle does not free a slot for a push.
REQ-020 SHALL make a flit pushed on edge N visible on dst_valid/dst_data after edge N (latency 1), with no same-cycle pass-through.
REQ-021 SHALL keep each queue in FIFO order, with pointers wrapping modulo DEPTH and count ranging 0..DEPTH.
REQ-022 SHALL allow a simultaneous push and pop on a non-full, non-empty queue, leaving its count unchanged.
REQ-023 SHALL pop only on a valid handshake, and SHALL hold dst_data stable while dst_valid=1 and dst_ready=0.
REQ-024 SHALL hold dst_valid[i]=0 when queue i is empty; dst_data then has no meaning.
REQ-025 SHALL let queues drain independently, so a full queue blocks only flits addressed to it.

Reset
REQ-026 SHALL, on reset assertion, immediately empty all queues, enter IDLE, clear the locked dest, clear drop_count, and drive dst_valid=0 and src_ready=0.
REQ-027 SHALL abandon any packet in progress when reset occurs mid-packet; flits after reset release are decoded as a new packet header.
REQ-028 SHALL drive src_ready=1 from the first cycle after reset release when the target queue has space.

Configuration
REQ-029 SHALL, with macro NOC_DROP_CNT_EN defined, increment drop_count once per packet on entry to DROP, saturating at 255.
REQ-030 SHALL, without NOC_DROP_CNT_EN, tie drop_count to 0 and compile no counter flops; the DROP routing behaviour is unchanged.

Structure
REQ-031 SHALL place the field widths, the PKT_W and flit-width constants, the flit struct typedef and the FSM state enum in package noc_pkg.
REQ-032 SHALL build each queue from one sub-module, noc_fifo, parametrised by width and DEPTH and instantiated NUM_DEST times by generate.

Verification
REQ-033 SHALL verify single flit: dest=1, payload=0xA5, eop=1, dst_ready=0 -> dst_valid=3'b010 on the next cycle, dst_data slice 1 = {1,0xA5,type}.
REQ-034 SHALL verify wormhole: 3-flit packet with header dest=2 and later flits carrying dest=0 -> all 3 flits in queue 2, queue 0 empty.
REQ-035 SHALL verify backpressure: 5 flits to dest=0 with DEPTH=4 and dst_ready=0 -> src_ready=0 after the 4th; raise dst_ready -> 5th accepted only on the cycle after the first pop.
REQ-036 SHALL verify invalid dest: dest=3 with NUM_DEST=3, a 2-flit packet -> both flits consumed with src_ready=1, no dst_valid, and drop_count=1 with the macro (0 without).
REQ-037 SHALL verify concurrent traffic: queue 1 full and stalled, packet to dest=0 -> accepted and delivered while queue 1 stays full.
REQ-038 SHALL verify reset mid-packet: 2 of 3 flits sent to dest=1, then assert reset -> dst_valid=0 and the FSM in IDLE, after which a flit with dest=0 routes to queue 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared widths, flit layout and routing-state encoding for the destination-queue NoC block.
package noc_pkg;

    localparam int unsigned NOC_ADDR_W    = 2;
    localparam int unsigned NOC_TYPE_W    = 2;
    localparam int unsigned NOC_PAYLOAD_W = 8;
    localparam int unsigned NOC_PKT_W     = NOC_ADDR_W + NOC_TYPE_W + NOC_PAYLOAD_W + 1;
    localparam int unsigned NOC_FLIT_W    = NOC_PKT_W - NOC_ADDR_W;

    // Queue-side flit: the dest field is stripped once routing has been decided.
    typedef struct packed {
        logic                     eop;
        logic [NOC_PAYLOAD_W-1:0] payload;
        logic [NOC_TYPE_W-1:0]    ptype;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } route_state_t;

endpackage

// File: rtl/noc_fifo.sv
// Single destination queue: registered count/full flags, no same-cycle pass-through.
module noc_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_full;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_push_en;
    logic             w_pop_en;

    assign w_push_en = i_push & ~r_full;
    assign w_pop_en  = i_pop & (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_en, w_pop_en})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_MAX);
        end
    end

    // Storage is not reset; validity comes solely from r_count.
    always_ff @(posedge i_clk) begin
        if (w_push_en) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_full  = r_full;

endmodule

// File: rtl/noc_dest_queue.sv
// Wormhole router into NUM_DEST per-destination FIFOs; unknown destinations are dropped.
// Define NOC_DROP_CNT_EN to build the saturating drop_count register (otherwise tied to 0).
module noc_dest_queue
    import noc_pkg::*;
#(
    parameter int NUM_DEST  = 3,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = NOC_ADDR_W,
    parameter int TYPE_W    = NOC_TYPE_W,
    parameter int PAYLOAD_W = NOC_PAYLOAD_W
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [ADDR_W+TYPE_W+PAYLOAD_W:0]                packet,
    input  logic                                            src_valid,
    output logic                                            src_ready,
    output logic [NUM_DEST-1:0]                             dst_valid,
    input  logic [NUM_DEST-1:0]                             dst_ready,
    output logic [NUM_DEST*(TYPE_W+PAYLOAD_W+1)-1:0]        dst_data,
    output logic [7:0]                                      drop_count
);

    localparam int PKT_W     = ADDR_W + TYPE_W + PAYLOAD_W + 1;
    localparam int FLIT_W    = PKT_W - ADDR_W;
    localparam int DEST_SPAN = 2**ADDR_W;

    route_state_t          r_state;
    route_state_t          w_state_nxt;
    logic [ADDR_W-1:0]     r_lock;
    logic [ADDR_W-1:0]     w_lock_nxt;
    logic [ADDR_W-1:0]     w_dest;
    logic                  w_eop;
    logic                  w_dest_ok;
    logic                  w_ready;
    logic                  w_accept;
    logic [NUM_DEST-1:0]   w_full;
    logic [DEST_SPAN-1:0]  w_full_ext;
    logic [DEST_SPAN-1:0]  w_push_ext;

    assign w_dest    = packet[ADDR_W-1:0];
    assign w_eop     = packet[PKT_W-1];
    assign w_dest_ok = (int'(w_dest) < NUM_DEST);

    // Unused destination slots read as full so they can never accept a push.
    always_comb begin
        w_full_ext                 = '1;
        w_full_ext[NUM_DEST-1:0]   = w_full;
    end

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            IDLE:    w_ready = w_dest_ok ? ~w_full_ext[w_dest] : 1'b1;
            IN_PKT:  w_ready = ~w_full_ext[r_lock];
            DROP:    w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
        if (reset) w_ready = 1'b0;
    end

    assign src_ready = w_ready;
    assign w_accept  = src_valid & w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock;
        w_push_ext  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_dest_ok) begin
                        w_push_ext[w_dest] = 1'b1;
                        if (!w_eop) begin
                            w_state_nxt = IN_PKT;
                            w_lock_nxt  = w_dest;
                        end
                    end else if (!w_eop) begin
                        w_state_nxt = DROP;
                    end
                end
            end
            IN_PKT: begin
                if (w_accept) begin
                    w_push_ext[r_lock] = 1'b1;
                    if (w_eop) w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (w_accept && w_eop) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_lock  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

`ifdef NOC_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_new_drop;

    // Counted on the dropped header, so single-flit bad packets are counted too.
    assign w_new_drop = w_accept && (r_state == IDLE) && !w_dest_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_new_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = '0;
`endif

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_queue
        noc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_push  (w_push_ext[g]),
            .i_data  (packet[PKT_W-1:ADDR_W]),
            .i_pop   (dst_ready[g]),
            .o_data  (dst_data[g*FLIT_W +: FLIT_W]),
            .o_valid (dst_valid[g]),
            .o_full  (w_full[g])
        );
    end

endmodule
